uart_tx_fifo: RTL and testbench

Memory-mapped UART transmitter that replaces the simulation-only UART sink in the core's store path. It accepts byte writes decoded from stores to address 0xFFFF_FFFC and buffers them in a small FIFO. A serializer FSM shifts each byte out on a single TX line as 8N1 frames. It reports full/busy status so the core, or a later status register, can throttle output.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a byte FIFO feeding an 8N1 serializer.
// Ports:
//   clk      core clock
//   rst      asynchronous active-high reset
//   wEn      byte write strobe, sampled on rising clk
//   data     byte to transmit, valid with wEn
//   txd      serial line, idles high
//   full     FIFO holds FIFO_DEPTH entries
//   busy     FIFO non-empty or serializer active
//   count    current FIFO occupancy
//   overflow sticky flag, set when a write is dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wEn,
    input  logic [7:0]                    data,
    output logic                          txd,
    output logic                          full,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wrPtr, rdPtr;
    logic          push, pop, baudLast;
    logic [7:0]    head, shiftReg, shiftNext;
    logic [BW-1:0] baudCnt, baudNext;
    logic [2:0]    bitIdx, bitNext;
    stateT         state, stateNext;

    // Pointers carry an extra wrap bit, so the difference is the occupancy.
    assign count    = wrPtr - rdPtr;
    assign full     = count == (AW + 1)'(FIFO_DEPTH);
    assign push     = wEn && !full;
    assign head     = mem[rdPtr[AW-1:0]];
    assign baudLast = baudCnt == BW'(CLKS_PER_BIT - 1);
    assign busy     = count != '0 || state != IDLE;
    // Decoded straight from state so an asynchronous reset idles the line at once.
    assign txd      = state == START ? 1'b0 : state == DATA ? shiftReg[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (wEn && full) overflow <= 1'b1;
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
        end
    end

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        baudNext  = baudLast ? '0 : baudCnt + 1'b1;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        case (state)
            IDLE: begin
                baudNext = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    shiftNext = head;
                    stateNext = START;
                end
            end
            START: begin
                if (baudLast) begin
                    stateNext = DATA;
                    bitNext   = '0;
                end
            end
            DATA: begin
                if (baudLast) begin
                    shiftNext = shiftReg >> 1;
                    bitNext   = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            default: begin
                // Chain straight into the next start bit when more data is waiting.
                if (baudLast) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        shiftNext = head;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       wEn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd, full, busy, overflow;
    logic [3:0] count;

    int   vectors = 0;
    int   miscompares = 0;
    logic rec = 1'b0;
    logic txLog[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wEn(wEn), .data(data),
        .txd(txd), .full(full), .busy(busy), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // txLog[k] holds txd shortly after edge k of the current test.
    always @(posedge clk) begin
        #1;
        if (rec) txLog.push_back(txd);
    end

    // Returns {shapeOk, byte} for a 40-sample frame starting at index s.
    function automatic logic [8:0] frameAt(int s);
        logic       ok;
        logic [7:0] b;
        logic       v, r;
        int         idx;
        ok = 1'b1;
        b  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                idx = s + i * 4 + j;
                v = (idx < txLog.size()) ? txLog[idx] : 1'bx;
                if (j == 0 && i >= 1 && i <= 8) begin
                    b[i-1] = v;
                    if (v === 1'bx) ok = 1'b0;
                end else begin
                    r = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
                    if (v !== r) ok = 1'b0;
                end
            end
        end
        return {ok, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vectors++;
        if ({txd, full, busy, count, overflow} !== 8'b1_0_0_0000_0) begin
            miscompares++;
            $display("FAIL reset_values: got txd/full/busy/count/ovf=%b required 1_0_0_0000_0", {txd, full, busy, count, overflow});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({txd, busy, count} !== 6'b1_0_0000) begin
            miscompares++;
            $display("FAIL reset_release: got txd/busy/count=%b required 1_0_0000", {txd, busy, count});
        end
    endtask

    task automatic test_single();
        logic [8:0] f;
        txLog.delete();
        @(negedge clk);
        rec = 1'b1; wEn = 1'b1; data = 8'hA5;
        @(negedge clk);
        wEn = 1'b0;
        vectors++;
        if (count !== 4'd1 || txd !== 1'b1) begin
            miscompares++;
            $display("FAIL single_edge0: got count=%0d txd=%b required count=1 txd=1", count, txd);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_stop: got busy=%b required 1", busy);
        end
        @(negedge clk);
        rec = 1'b0;
        vectors++;
        if ({busy, count, txd} !== 6'b0_0000_1) begin
            miscompares++;
            $display("FAIL single_done: got busy/count/txd=%b required 0_0000_1", {busy, count, txd});
        end
        f = frameAt(1);
        vectors++;
        if (f !== {1'b1, 8'hA5} || txLog[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_frame: got ok/byte=%h pre=%b required 1a5 pre=1", f, txLog[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3] = '{8'h55, 8'h0F, 8'hFF};
        logic [8:0] f;
        txLog.delete();
        @(negedge clk);
        rec = 1'b1; wEn = 1'b1; data = 8'h55;
        @(negedge clk); data = 8'h0F;
        @(negedge clk); data = 8'hFF;
        @(negedge clk); wEn = 1'b0;
        vectors++;
        if (count !== 4'd2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d required 2", count);
        end
        repeat (119) @(negedge clk);
        rec = 1'b0;
        vectors++;
        if (busy !== 1'b0 || txLog[121] !== 1'b1 || txLog[120] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_done: got busy=%b required 0", busy);
        end
        for (int k = 0; k < 3; k++) begin
            f = frameAt(1 + 40 * k);
            vectors++;
            if (f !== {1'b1, exp[k]}) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got ok/byte=%h required 1%h", k, f, exp[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] f;
        txLog.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                vectors++;
                if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full: got count=%0d full=%b ovf=%b required 8 1 0", count, full, overflow);
                end
            end
            rec = 1'b1; wEn = 1'b1; data = 8'h10 + 8'(i);
        end
        @(negedge clk);
        wEn = 1'b0;
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drop: got count=%0d ovf=%b required 8 1", count, overflow);
        end
        repeat (352) @(negedge clk);
        rec = 1'b0;
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b1 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL ovf_drain: got busy=%b ovf=%b count=%0d required 0 1 0", busy, overflow, count);
        end
        for (int k = 0; k < 9; k++) begin
            f = frameAt(1 + 40 * k);
            vectors++;
            if (f !== {1'b1, 8'h10 + 8'(k)}) begin
                miscompares++;
                $display("FAIL ovf_frame%0d: got ok/byte=%h required 1%h", k, f, 8'h10 + 8'(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] f;
        logic [7:0] b;
        for (int r = 0; r < 3; r++) begin
            txLog.delete();
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                rec = 1'b1; wEn = 1'b1; data = 8'(r * 37 + i * 11 + 1);
            end
            @(negedge clk);
            wEn = 1'b0;
            repeat (236) @(negedge clk);
            rec = 1'b0;
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_round%0d_idle: got busy=%b required 0", r, busy);
            end
            for (int k = 0; k < 6; k++) begin
                f = frameAt(1 + 40 * k);
                b = 8'(r * 37 + k * 11 + 1);
                vectors++;
                if (f !== {1'b1, b}) begin
                    miscompares++;
                    $display("FAIL wrap_r%0d_f%0d: got ok/byte=%h required 1%h", r, k, f, b);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] f;
        @(negedge clk); wEn = 1'b1; data = 8'hF0;
        @(negedge clk); data = 8'h11;
        @(negedge clk); data = 8'h22;
        @(negedge clk); wEn = 1'b0;
        repeat (16) @(negedge clk);
        vectors++;
        if (txd !== 1'b0 || count !== 4'd2) begin
            miscompares++;
            $display("FAIL mid_pre: got txd=%b count=%0d required 0 2", txd, count);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({txd, full, busy, count, overflow} !== 8'b1_0_0_0000_0) begin
            miscompares++;
            $display("FAIL mid_reset: got txd/full/busy/count/ovf=%b required 1_0_0_0000_0", {txd, full, busy, count, overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        txLog.delete();
        rec = 1'b1;
        repeat (50) @(negedge clk);
        rec = 1'b0;
        f = 9'h000;
        foreach (txLog[i]) if (txLog[i] !== 1'b1) f = 9'h1FF;
        vectors++;
        if (f !== 9'h000 || busy !== 1'b0 || txLog.size() != 50) begin
            miscompares++;
            $display("FAIL mid_quiet: got busy=%b activity=%b required quiet idle line", busy, f[0]);
        end
        txLog.delete();
        @(negedge clk);
        rec = 1'b1; wEn = 1'b1; data = 8'h3C;
        @(negedge clk);
        wEn = 1'b0;
        repeat (41) @(negedge clk);
        rec = 1'b0;
        f = frameAt(1);
        vectors++;
        if (f !== {1'b1, 8'h3C} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after: got ok/byte=%h busy=%b required 13c 0", f, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
